// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and width helpers for the round-robin mux arbiter and its
// priority-encoder building block.
package rr_mux_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Ceiling log2 for elaboration-time width derivation (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 32; i++) begin
            if ((64'sd1 << i) < longint'(value)) begin
                result = i + 32'sd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Select width: never narrower than one bit, even for a single source.
    function automatic int sel_width(input int n_req);
        if (clog2(n_req) < 32'sd1) begin
            return 32'sd1;
        end else begin
            return clog2(n_req);
        end
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Request/response bundle between the requesting sources, the arbiter and
// the downstream consumer of the muxed stream.
interface rr_mux_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 4,
    parameter int SEL_W  = rr_mux_arb_pkg::sel_width(N_REQ)
) ();
    import rr_mux_arb_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        gnt;
    logic [SEL_W-1:0]        sel;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    logic                    out_ready;

    // Arbiter side.
    modport slave (
        input  req, req_data, req_last, out_ready,
        output gnt, sel, out_valid, out_data, out_last
    );

    // Sources plus consumer side.
    modport master (
        output req, req_data, req_last, out_ready,
        input  gnt, sel, out_valid, out_data, out_last
    );

endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational rotating priority encoder: returns the first set request at
// or above ptr, wrapping past N_REQ-1 back to 0.
module rr_pick
    import rr_mux_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int SEL_W = sel_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] rot_s;
    logic [SEL_W:0]   sum_s;
    logic             found_s;

    // Rotate requests so bit 0 is the ptr position, then take the lowest set bit.
    always_comb begin
        rot_s   = N_REQ'({req, req} >> ptr);
        idx     = '0;
        sum_s   = '0;
        found_s = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found_s && rot_s[k]) begin
                sum_s = {1'b0, ptr} + (SEL_W+1)'(k);
                if (sum_s >= (SEL_W+1)'(N_REQ)) begin
                    idx = SEL_W'(sum_s - (SEL_W+1)'(N_REQ));
                end else begin
                    idx = SEL_W'(sum_s);
                end
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter and sequencer for a shared N-input mux. One owner at a
// time drives a valid/ready stream; ownership is released on last beat,
// after MAX_HOLD beats, or when the owner drops its request.
module rr_mux_arbiter
    import rr_mux_arb_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int DATA_W   = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_mux_arbiter_if.slave bus
);

    localparam int SEL_W = sel_width(N_REQ);
    localparam int CNT_W = clog2(MAX_HOLD + 1);

    arb_state_e        state_r;
    logic [SEL_W-1:0]  owner_r;
    logic [SEL_W-1:0]  ptr_r;
    logic [CNT_W-1:0]  beat_cnt_r;

    logic              pick_any_s;
    logic [SEL_W-1:0]  pick_idx_s;
    logic [DATA_W-1:0] data_arr_s [N_REQ];
    logic              owner_req_s;
    logic              owner_last_s;
    logic [DATA_W-1:0] owner_data_s;
    logic [N_REQ-1:0]  gnt_s;
    logic              out_valid_s;
    logic [DATA_W-1:0] out_data_s;
    logic              out_last_s;
    logic              transfer_s;
    logic              release_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [SEL_W-1:0]  ptr_next_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req (bus.req),
        .ptr (ptr_r),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    // Split the flat data bus into per-requester lanes for indexed selection.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            data_arr_s[k] = bus.req_data[k*DATA_W +: DATA_W];
        end
    end

    // Only the owner's lane is ever selected, so non-owner data cannot leak out.
    assign owner_req_s  = bus.req[owner_r];
    assign owner_last_s = bus.req_last[owner_r];
    assign owner_data_s = data_arr_s[owner_r];

    // Output steering: live only in GRANT; IDLE presents an all-zero, invalid beat.
    always_comb begin
        gnt_s       = '0;
        out_valid_s = 1'b0;
        out_data_s  = '0;
        out_last_s  = 1'b0;
        if (state_r == GRANT) begin
            out_valid_s    = owner_req_s;
            out_data_s     = owner_data_s;
            out_last_s     = owner_last_s;
            gnt_s[owner_r] = bus.out_ready & owner_req_s;
        end else begin
            gnt_s       = '0;
            out_valid_s = 1'b0;
        end
    end

    assign transfer_s = out_valid_s & bus.out_ready;
    assign cnt_next_s = beat_cnt_r + CNT_W'(1);
    assign release_s  = (state_r == GRANT) &
                        ((transfer_s & owner_last_s) |
                         (transfer_s & (cnt_next_s == CNT_W'(MAX_HOLD))) |
                         !owner_req_s);
    assign ptr_next_s = (owner_r == SEL_W'(N_REQ - 1)) ? SEL_W'(0) : (owner_r + SEL_W'(1));

    // Arbitration FSM: pick a winner in IDLE, count beats and release in GRANT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            owner_r    <= '0;
            ptr_r      <= '0;
            beat_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_any_s) begin
                        owner_r    <= pick_idx_s;
                        beat_cnt_r <= '0;
                        state_r    <= GRANT;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                GRANT: begin
                    if (transfer_s) begin
                        beat_cnt_r <= cnt_next_s;
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                    if (release_s) begin
                        state_r <= IDLE;
                        ptr_r   <= ptr_next_s;
                    end else begin
                        state_r <= GRANT;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    beat_cnt_r <= '0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_s;
    assign bus.sel       = owner_r;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = out_data_s;
    assign bus.out_last  = out_last_s;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_rr_mux_arbiter;

    localparam int N_REQ    = 2;
    localparam int DATA_W   = 4;
    localparam int MAX_HOLD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    rr_mux_arbiter #(
        .N_REQ    (N_REQ),
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the mux, where the search starts, beats taken.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_beats;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_beats = 0;
    endtask

    function automatic logic [31:0] lane_req(input int i);
        return 32'((bus.req >> i) & 2'b01);
    endfunction

    function automatic logic [31:0] lane_last(input int i);
        return 32'((bus.req_last >> i) & 2'b01);
    endfunction

    function automatic logic [31:0] lane_data(input int i);
        return 32'((bus.req_data >> (i * DATA_W)) & 8'h0F);
    endfunction

    task automatic check_outputs();
        logic [31:0] ev, ed, el, eg;
        ev = 32'd0; ed = 32'd0; el = 32'd0; eg = 32'd0;
        if (m_busy) begin
            ev = lane_req(m_owner);
            ed = lane_data(m_owner);
            el = lane_last(m_owner);
            eg = (ev != 32'd0 && bus.out_ready) ? (32'd1 << m_owner) : 32'd0;
        end
        check_val("out_valid", bus.out_valid, ev);
        check_val("out_data",  bus.out_data,  ed);
        check_val("out_last",  bus.out_last,  el);
        check_val("gnt",       bus.gnt,       eg);
        check_val("sel",       bus.sel,       32'(m_owner));
    endtask

    task automatic model_advance();
        bit xfer;
        bit found;
        int i;
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                i = (m_ptr + k) % N_REQ;
                if (!found && lane_req(i) != 32'd0) begin
                    found   = 1'b1;
                    m_owner = i;
                    m_busy  = 1'b1;
                    m_beats = 0;
                end
            end
        end else begin
            xfer = (lane_req(m_owner) != 32'd0) && bus.out_ready;
            if (xfer) m_beats++;
            if ((xfer && lane_last(m_owner) != 32'd0) || (xfer && m_beats == MAX_HOLD) ||
                lane_req(m_owner) == 32'd0) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N_REQ;
            end
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic [1:0] r, input logic [7:0] d, input logic [1:0] l, input logic rdy);
        @(negedge clk);
        bus.req       = r;
        bus.req_data  = d;
        bus.req_last  = l;
        bus.out_ready = rdy;
        #1;
        check_outputs();
        model_advance();
    endtask

    // Assert reset between clock edges and check the outputs clear before the next edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_val({tag, "_gnt"},   bus.gnt,       32'd0);
        check_val({tag, "_valid"}, bus.out_valid, 32'd0);
        check_val({tag, "_sel"},   bus.sel,       32'd0);
        check_val({tag, "_data"},  bus.out_data,  32'd0);
        model_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 2'b00;
    endtask

    int exp_d [12] = '{0, 3, 3, 3, 3, 0, 2, 2, 2, 2, 0, 3};
    int exp_s [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    logic [1:0] rnd_req;
    logic [1:0] rnd_last;

    initial begin
        bus.req       = 2'b00;
        bus.req_data  = 8'h00;
        bus.req_last  = 2'b00;
        bus.out_ready = 1'b1;
        model_reset();

        // Reset state while rst_n is held low.
        #2;
        check_val("rst_gnt",   bus.gnt,       32'd0);
        check_val("rst_valid", bus.out_valid, 32'd0);
        check_val("rst_sel",   bus.sel,       32'd0);
        check_val("rst_data",  bus.out_data,  32'd0);
        check_val("rst_last",  bus.out_last,  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, one-beat burst; then ptr=1 and req0 alone wins by wrap.
        step(2'b01, 8'h03, 2'b01, 1'b1);
        step(2'b01, 8'h03, 2'b01, 1'b1);
        check_val("single_valid", bus.out_valid, 32'd1);
        check_val("single_data",  bus.out_data,  32'd3);
        check_val("single_gnt",   bus.gnt,       32'd1);
        step(2'b01, 8'h03, 2'b01, 1'b1);
        check_val("wrap_idle", bus.out_valid, 32'd0);
        step(2'b01, 8'h03, 2'b01, 1'b1);
        check_val("wrap_sel",  bus.sel,       32'd0);
        check_val("wrap_gnt",  bus.gnt,       32'd1);

        // Async reset mid-GRANT with requester 1 owning the mux.
        step(2'b10, 8'h23, 2'b00, 1'b1);
        step(2'b10, 8'h23, 2'b00, 1'b1);
        check_val("pre_rst_sel", bus.sel, 32'd1);
        async_reset("midrst");

        // Contention with both requesters held: 4 beats each plus one bubble.
        for (int c = 0; c < 12; c++) begin
            step(2'b11, 8'h23, 2'b00, 1'b1);
            check_val("cont_valid", bus.out_valid, (exp_d[c] != 0) ? 32'd1 : 32'd0);
            check_val("cont_data",  bus.out_data,  32'(exp_d[c]));
            check_val("cont_sel",   bus.sel,       32'(exp_s[c]));
        end
        step(2'b00, 8'h00, 2'b00, 1'b1);
        step(2'b00, 8'h00, 2'b00, 1'b1);

        // Backpressure: owner holds valid with stable data, no grant, no beat counted.
        step(2'b01, 8'h03, 2'b00, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(2'b01, 8'h03, 2'b00, 1'b0);
            check_val("bp_valid", bus.out_valid, 32'd1);
            check_val("bp_gnt",   bus.gnt,       32'd0);
            check_val("bp_data",  bus.out_data,  32'd3);
        end
        for (int c = 0; c < 4; c++) begin
            step(2'b01, 8'h03, 2'b00, 1'b1);
            check_val("bp_beat", bus.gnt, 32'd1);
        end
        step(2'b01, 8'h03, 2'b00, 1'b1);
        check_val("bp_release", bus.out_valid, 32'd0);
        step(2'b00, 8'h00, 2'b00, 1'b1);

        // Owner drop after two beats hands over to requester 1.
        step(2'b00, 8'h00, 2'b00, 1'b1);
        step(2'b01, 8'h23, 2'b00, 1'b1);
        step(2'b11, 8'h23, 2'b00, 1'b1);
        step(2'b11, 8'h23, 2'b00, 1'b1);
        step(2'b10, 8'h23, 2'b00, 1'b1);
        check_val("drop_valid", bus.out_valid, 32'd0);
        step(2'b10, 8'h23, 2'b00, 1'b1);
        step(2'b10, 8'h23, 2'b00, 1'b1);
        check_val("drop_sel",  bus.sel,      32'd1);
        check_val("drop_data", bus.out_data, 32'd2);

        // Randomized traffic with sticky requests and occasional async resets.
        rnd_req = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N_REQ; b++) begin
                if ($urandom_range(0, 3) == 0) rnd_req[b] = ~rnd_req[b];
                rnd_last[b] = ($urandom_range(0, 3) == 0);
            end
            step(rnd_req, 8'($urandom), rnd_last, ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rnd_rst");
                rnd_req = 2'b00;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
